// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic_pkg
// Purpose  : Shared types and constants for the PIC command register file:
//            init FSM state encoding, OCW2 command codes, ICW/OCW bit fields.
// Revision : 1.0 - initial release
// ============================================================================
package pic_pkg;

  // Initialisation sequence states
  typedef enum logic [2:0] {
    ST_UNINIT = 3'd0,
    ST_W_ICW2 = 3'd1,
    ST_W_ICW3 = 3'd2,
    ST_W_ICW4 = 3'd3,
    ST_READY  = 3'd4
  } pic_state_t;

  // OCW2 R/SL/EOI command codes
  localparam logic [2:0] NS_EOI       = 3'b001;
  localparam logic [2:0] SP_EOI       = 3'b011;
  localparam logic [2:0] ROT_NS       = 3'b101;
  localparam logic [2:0] ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] ROT_SP       = 3'b111;
  localparam logic [2:0] SET_PRI      = 3'b110;

  // ICW1 / ICW4 field positions
  localparam int c_icw1_ic4  = 0;
  localparam int c_icw1_sngl = 1;
  localparam int c_icw1_ltim = 3;
  localparam int c_cmd_sel   = 4;   // a0=0: 1 selects ICW1
  localparam int c_icw4_aeoi = 1;

  // OCW3 field positions
  localparam int c_ocw3_sel  = 3;   // with bit 4 clear: 1 selects OCW3, 0 OCW2
  localparam int c_ocw3_ris  = 0;
  localparam int c_ocw3_rr   = 1;
  localparam int c_ocw3_p    = 2;
  localparam int c_ocw3_smm  = 5;
  localparam int c_ocw3_esmm = 6;

  // An a0=0 write with bit 4 set is always ICW1, regardless of state
  function automatic logic is_icw1(input logic a0, input logic [7:0] d);
    return !a0 && d[c_cmd_sel];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pic_wr_edge.sv
`default_nettype none
// ============================================================================
// Module   : pic_wr_edge
// Purpose  : Turns a CPU write strobe (cs_n & wr_n low) into a single-cycle
//            write event on the strobe's leading edge; read-conflicted writes
//            are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module pic_wr_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_cs_n,
  input  logic i_wr_n,
  input  logic i_rd_n,
  output logic o_wr_evt
);

  logic w_wr_now;
  logic r_wr_prev;

  assign w_wr_now = !i_cs_n && !i_wr_n;

  // Track last cycle's strobe; reset arms it as "active" so a strobe held
  // across reset release must be seen inactive before it can commit again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wr_prev <= 1'b1;
    else        r_wr_prev <= w_wr_now;
  end

  assign o_wr_evt = w_wr_now && !r_wr_prev && i_rd_n;

endmodule
`default_nettype wire

// File: rtl/pic_cmd_regfile.sv
`default_nettype none
// ============================================================================
// Module   : pic_cmd_regfile
// Purpose  : PIC command decoder and configuration register file. Runs the
//            ICW1..ICW4 initialisation FSM, holds OCW state, emits one-cycle
//            command pulses and serves IRR/ISR/IMR reads.
// Options  : PIC_SPECIAL_MASK_EN - enables OCW3 ESMM/SMM special mask mode.
// Revision : 1.0 - initial release
// ============================================================================
module pic_cmd_regfile
  import pic_pkg::*;
#(
  parameter int         N_IRQ   = 8,
  parameter logic [7:0] IMR_RST = 8'h00,
  parameter int         VEC_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             wr_n,
  input  logic             rd_n,
  input  logic             a0,
  input  logic             sp_en_n,
  input  logic [7:0]       din,
  input  logic [N_IRQ-1:0] irr,
  input  logic [N_IRQ-1:0] isr,
  output logic [7:0]       dout,
  output logic             dout_oe,
  output logic             init_done,
  output logic [VEC_W-1:0] vec_base,
  output logic             ltim,
  output logic             sngl,
  output logic [7:0]       icw3,
  output logic             aeoi,
  output logic [N_IRQ-1:0] imr,
  output logic             ocw2_valid,
  output logic [2:0]       ocw2_cmd,
  output logic [2:0]       ocw2_lvl,
  output logic             read_isr,
  output logic             poll_req,
  output logic             smm,
  output logic             cmd_err
);

  logic             w_wr_evt;
  logic [7:0]       w_imr_ext;
  logic [7:0]       w_rr_ext;

  pic_state_t       r_state;
  logic             r_init_done;
  logic [VEC_W-1:0] r_vec_base;
  logic             r_ltim;
  logic             r_sngl;
  logic             r_ic4;
  logic [7:0]       r_icw3;
  logic             r_aeoi;
  logic [N_IRQ-1:0] r_imr;
  logic             r_ocw2_valid;
  logic [2:0]       r_ocw2_cmd;
  logic [2:0]       r_ocw2_lvl;
  logic             r_read_isr;
  logic             r_poll_req;
  logic             r_smm;
  logic             r_cmd_err;

  pic_wr_edge u_wr_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_cs_n   (cs_n),
    .i_wr_n   (wr_n),
    .i_rd_n   (rd_n),
    .o_wr_evt (w_wr_evt)
  );

  // Initialisation FSM plus all configuration registers and command pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_UNINIT;
      r_init_done  <= 1'b0;
      r_vec_base   <= '0;
      r_ltim       <= 1'b0;
      r_sngl       <= 1'b0;
      r_ic4        <= 1'b0;
      r_icw3       <= 8'h00;
      r_aeoi       <= 1'b0;
      r_imr        <= IMR_RST[N_IRQ-1:0];
      r_ocw2_valid <= 1'b0;
      r_ocw2_cmd   <= 3'b000;
      r_ocw2_lvl   <= 3'b000;
      r_read_isr   <= 1'b0;
      r_poll_req   <= 1'b0;
      r_smm        <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_ocw2_valid <= 1'b0;
      r_poll_req   <= 1'b0;
      r_cmd_err    <= 1'b0;
      if (w_wr_evt) begin
        if (is_icw1(a0, din)) begin
          r_ltim      <= din[c_icw1_ltim];
          r_sngl      <= din[c_icw1_sngl];
          r_ic4       <= din[c_icw1_ic4];
          r_aeoi      <= 1'b0;
          r_smm       <= 1'b0;
          r_read_isr  <= 1'b0;
          r_icw3      <= 8'h00;
          r_imr       <= IMR_RST[N_IRQ-1:0];
          r_state     <= ST_W_ICW2;
          r_init_done <= 1'b0;
        end else begin
          case (r_state)
            ST_READY: begin
              if (a0) begin
                r_imr <= din[N_IRQ-1:0];
              end else if (!din[c_ocw3_sel]) begin
                r_ocw2_cmd   <= din[7:5];
                r_ocw2_lvl   <= din[2:0];
                r_ocw2_valid <= 1'b1;
              end else begin
                if (din[c_ocw3_rr]) r_read_isr <= din[c_ocw3_ris];
                r_poll_req <= din[c_ocw3_p];
`ifdef PIC_SPECIAL_MASK_EN
                if (din[c_ocw3_esmm]) r_smm <= din[c_ocw3_smm];
`endif
              end
            end
            ST_W_ICW2: begin
              if (!a0) begin
                r_cmd_err <= 1'b1;
              end else begin
                r_vec_base <= din[7 -: VEC_W];
                if (!r_sngl) begin
                  r_state <= ST_W_ICW3;
                end else if (r_ic4) begin
                  r_state <= ST_W_ICW4;
                end else begin
                  r_state     <= ST_READY;
                  r_init_done <= 1'b1;
                end
              end
            end
            ST_W_ICW3: begin
              if (!a0) begin
                r_cmd_err <= 1'b1;
              end else begin
                // A slave only keeps its 3-bit cascade identity
                r_icw3 <= sp_en_n ? din : {5'b00000, din[2:0]};
                if (r_ic4) begin
                  r_state <= ST_W_ICW4;
                end else begin
                  r_state     <= ST_READY;
                  r_init_done <= 1'b1;
                end
              end
            end
            ST_W_ICW4: begin
              if (!a0) begin
                r_cmd_err <= 1'b1;
              end else begin
                r_aeoi      <= din[c_icw4_aeoi];
                r_state     <= ST_READY;
                r_init_done <= 1'b1;
              end
            end
            default: begin
              // Uninitialised: only ICW1 is meaningful, a0=1 data is ignored
              if (!a0) r_cmd_err <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  // Zero-extend the N_IRQ-wide readback sources onto the 8-bit bus
  always_comb begin
    w_imr_ext              = 8'h00;
    w_imr_ext[N_IRQ-1:0]   = r_imr;
    w_rr_ext               = 8'h00;
    w_rr_ext[N_IRQ-1:0]    = r_read_isr ? isr : irr;
  end

  assign dout_oe    = !cs_n && !rd_n && wr_n;
  assign dout       = !dout_oe ? 8'h00 : (a0 ? w_imr_ext : w_rr_ext);

  assign init_done  = r_init_done;
  assign vec_base   = r_vec_base;
  assign ltim       = r_ltim;
  assign sngl       = r_sngl;
  assign icw3       = r_icw3;
  assign aeoi       = r_aeoi;
  assign imr        = r_imr;
  assign ocw2_valid = r_ocw2_valid;
  assign ocw2_cmd   = r_ocw2_cmd;
  assign ocw2_lvl   = r_ocw2_lvl;
  assign read_isr   = r_read_isr;
  assign poll_req   = r_poll_req;
  assign smm        = r_smm;
  assign cmd_err    = r_cmd_err;

endmodule
`default_nettype wire

// File: doc/pic_cmd_regfile.md
Name: pic_cmd_regfile

Overview:
- Clocked, parametrised successor to the PIC read/write command logic.
- Decodes CPU writes into ICW1–ICW4 and OCW1–OCW3 through an explicit initialisation FSM.
- Holds the programmed configuration and drives one-cycle command pulses to the priority/ISR logic.
- Returns IRR/ISR/IMR on CPU reads; sits between the data bus buffer and the interrupt core.

Parameters:
- N_IRQ, 8, number of interrupt lines, legal 1..8; mask and readback bits at index N_IRQ and above read as 0.
- IMR_RST, 0, IMR value loaded at reset and on every ICW1 (low N_IRQ bits used).
- VEC_W, 5, width of the vector base taken from ICW2[7:8-VEC_W]; fixed at 5 for 8086 mode.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cs_n  in  1  chip select, synchronous to clk.
- wr_n  in  1  write strobe, synchronous to clk.
- rd_n  in  1  read strobe, synchronous to clk.
- a0  in  1  register address bit.
- sp_en_n  in  1  1 = master, 0 = slave.
- din  in  8  CPU write data.
- irr  in  N_IRQ  interrupt request register from the core.
- isr  in  N_IRQ  in-service register from the core.
- dout  out  8  read data.
- dout_oe  out  1  read data valid / drive enable.
- init_done  out  1  initialisation sequence complete.
- vec_base  out  VEC_W  ICW2 vector base.
- ltim  out  1  ICW1 level-triggered mode.
- sngl  out  1  ICW1 single mode.
- icw3  out  8  master: slave-present mask; slave: {5'b0, id}.
- aeoi  out  1  ICW4 auto-EOI.
- imr  out  N_IRQ  interrupt mask.
- ocw2_valid  out  1  one-cycle pulse on an OCW2 write.
- ocw2_cmd  out  3  OCW2 R/SL/EOI bits.
- ocw2_lvl  out  3  OCW2 L2..L0.
- read_isr  out  1  0 = A0=0 reads return IRR, 1 = ISR.
- poll_req  out  1  one-cycle pulse on an OCW3 with P=1.
- smm  out  1  special mask mode.
- cmd_err  out  1  one-cycle pulse on an illegal write.

Behaviour:
- Write event: cs_n=0 & wr_n=0 in this cycle while not both low in the previous cycle (registered edge detect).
  - A long strobe commits exactly once.
  - Writes with rd_n=0 in the same cycle are ignored.
- Reset: FSM=UNINIT; all config registers, imr=IMR_RST, and all outputs 0.
- FSM states: UNINIT, W_ICW2, W_ICW3, W_ICW4, READY.
- ICW1 (write, a0=0, din[4]=1) is accepted from any state:
  - Loads ltim=din[3], sngl=din[1], ic4=din[0].
  - Clears aeoi, smm, read_isr, icw3; imr=IMR_RST; next state W_ICW2; init_done=0.
- W_ICW2, a0=1: vec_base=din[7:3].
  - Next state: W_ICW3 if !sngl, else W_ICW4 if ic4, else READY.
- W_ICW3, a0=1: icw3 = sp_en_n ? din : {5'b0, din[2:0]}.
  - Next state: W_ICW4 if ic4, else READY.
- W_ICW4, a0=1: aeoi=din[1]; next state READY.
- Any a0=0, din[4]=0 write outside READY is an illegal write:
  - cmd_err pulses one cycle; state and registers unchanged.
- READY:
  - a0=1 → imr=din[N_IRQ-1:0] (OCW1).
  - a0=0, din[4:3]=00 → OCW2: ocw2_cmd=din[7:5], ocw2_lvl=din[2:0], ocw2_valid pulses 1 cycle.
  - a0=0, din[4:3]=01 → OCW3:
    - din[1]=1 → read_isr=din[0]; din[1]=0 → read_isr unchanged.
    - din[2]=1 → poll_req pulses 1 cycle.
    - Special-mask bits: see Optional Feature.
- init_done=1 exactly when state=READY, registered.
- All pulse outputs are registered and asserted in the cycle after the write event.
- Read path, combinational from registers:
  - dout_oe = !cs_n & !rd_n & wr_n.
  - a0=1 → dout = zero-extended imr.
  - a0=0 → dout = zero-extended read_isr ? isr : irr.
  - dout = 0 when dout_oe=0.
- ICW1 arriving mid-sequence or in READY restarts initialisation with no residual pulses.
- rst_n asserted mid-strobe: the edge detector is cleared, so a strobe still held low after release does not commit.

Optional Feature:
- Macro PIC_SPECIAL_MASK_EN.
- Defined: OCW3 din[6]=1 (ESMM) sets smm=din[5]; din[6]=0 leaves smm unchanged.
- Undefined: smm tied 0 and din[6:5] ignored.

Decomposition:
- Package pic_pkg holds:
  - State enum (UNINIT..READY).
  - OCW2 command codes: NS_EOI=3'b001, SP_EOI=3'b011, ROT_NS=3'b101, ROT_AEOI_SET=3'b100, ROT_AEOI_CLR=3'b000, ROT_SP=3'b111, SET_PRI=3'b110.
  - Bit-position constants for ICW1/OCW3 fields.
- One sub-module, pic_wr_edge: the strobe edge detector producing the write-event pulse.

Test Plan:
- Reset, then ICW1=0x13, ICW2=0x40, ICW4=0x03 → vec_base=5'h08, sngl=1, aeoi=1, init_done=1 one cycle after ICW4; icw3=0.
- ICW1=0x11, ICW2=0x08, ICW3=0x04 with sp_en_n=1, ICW4=0x01 → icw3=0x04; repeat with sp_en_n=0 and ICW3=0xFE → icw3=0x06.
- In READY: OCW1 0xA5 → imr=0xA5 (N_IRQ=8) and read a0=1 → dout=0xA5; with N_IRQ=4 the same write → imr=4'h5 and dout=0x05.
- OCW2=0x63 → ocw2_valid high exactly 1 cycle with ocw2_cmd=3'b011, ocw2_lvl=3; OCW2 write before init → cmd_err pulse, no ocw2_valid.
- OCW3=0x0B then read a0=0 with isr=0x10, irr=0x81 → dout=0x10; OCW3=0x0A → dout=0x81; OCW3=0x0C → poll_req 1-cycle pulse.
- ICW1 written in READY with imr=0xFF → imr=IMR_RST, init_done=0 next cycle; a wr_n held low for 5 cycles commits once.
